vga_number_render: RTL and testbench

VGA_NUMBER_RENDER -- requirements
Module: vga_number_render

---
 rtl/vga_number_render_if.sv | 21 ++
 rtl/vga_number_render.sv | 182 ++++++++++++++++++
 tb/tb_vga_number_render.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_number_render_if.sv
// Value-offer handshake into vga_number_render: data qualified by valid,
// accepted on a rising edge while ready is high.
interface vga_number_render_if #(
    parameter int unsigned VAL_W = 16
);
    logic [VAL_W-1:0] val_data;
    logic             val_valid;
    logic             val_ready;

    modport master (
        output val_data,
        output val_valid,
        input  val_ready
    );

    modport slave (
        input  val_data,
        input  val_valid,
        output val_ready
    );
endinterface

// File: rtl/vga_number_render.sv
// Binary value -> decimal digits (serial double-dabble) rendered as an 8x16
// glyph field overlay on a pixel stream, two-cycle pixel pipeline.
module vga_number_render #(
    parameter int unsigned VAL_W      = 16,
    parameter int unsigned NUM_DIGITS = 5,
    parameter int unsigned SCALE_LOG2 = 0,
    parameter int unsigned X0         = 0,
    parameter int unsigned Y0         = 0,
    parameter bit          LEAD_BLANK = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    vga_number_render_if.slave       val,
    output logic                     busy,
    output logic                     ovf,
    input  logic [10:0]              px_x,
    input  logic [9:0]               px_y,
    input  logic                     px_de,
    output logic                     pixel,
    output logic                     de_out
);

    localparam int unsigned BCD_D   = (VAL_W * 3) / 10 + 1;
    localparam int unsigned SCR_D   = (BCD_D > NUM_DIGITS) ? BCD_D : NUM_DIGITS;
    localparam int unsigned CNT_W   = $clog2(VAL_W);
    localparam int unsigned FIELD_W = (NUM_DIGITS * 8) << SCALE_LOG2;
    localparam int unsigned FIELD_H = 16 << SCALE_LOG2;
    localparam logic [NUM_DIGITS*4-1:0] NINES = {NUM_DIGITS{4'h9}};

    typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

    state_t                  state_q;
    logic                    ready_q, busy_q, ovf_q;
    logic [VAL_W-1:0]        shift_q;
    logic [SCR_D*4-1:0]      bcd_q, bcd_d, adj_c;
    logic                    carry_q, carry_d, hi_nz_c;
    logic [CNT_W-1:0]        cnt_q;
    logic [NUM_DIGITS*4-1:0] disp_q;

    // Add-3 on every digit >= 5, then shift in the next input bit.
    always_comb begin
        adj_c = bcd_q;
        for (int unsigned i = 0; i < SCR_D; i++) begin
            if (adj_c[4*i +: 4] >= 4'd5)
                adj_c[4*i +: 4] = adj_c[4*i +: 4] + 4'd3;
        end
        bcd_d   = {adj_c[SCR_D*4-2:0], shift_q[VAL_W-1]};
        carry_d = carry_q | adj_c[SCR_D*4-1];
        hi_nz_c = carry_q;
        for (int unsigned i = NUM_DIGITS; i < SCR_D; i++)
            hi_nz_c = hi_nz_c | (|bcd_q[4*i +: 4]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            shift_q <= '0;
            bcd_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            disp_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (val.val_valid) begin
                        shift_q <= val.val_data;
                        bcd_q   <= '0;
                        carry_q <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= CONVERT;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                CONVERT: begin
                    bcd_q   <= bcd_d;
                    carry_q <= carry_d;
                    shift_q <= {shift_q[VAL_W-2:0], 1'b0};
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(VAL_W - 1))
                        state_q <= COMMIT;
                end
                COMMIT: begin
                    if (hi_nz_c) begin
                        disp_q <= NINES;
                        ovf_q  <= 1'b1;
                    end else begin
                        disp_q <= bcd_q[NUM_DIGITS*4-1:0];
                        ovf_q  <= 1'b0;
                    end
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign val.val_ready = ready_q;
    assign busy          = busy_q;
    assign ovf           = ovf_q;

    function automatic logic [127:0] glyph(input logic [3:0] code);
        case (code)
            4'd0:    glyph = 128'h0000_3C66_6666_6666_6666_6666_663C_0000;
            4'd1:    glyph = 128'h0000_0000_0000_1818_1818_1818_1818_1818;
            4'd2:    glyph = 128'h0000_3C66_0606_0C18_3060_6060_607E_0000;
            4'd3:    glyph = 128'h0000_3C66_0606_061C_0606_0606_663C_0000;
            4'd4:    glyph = 128'h0000_0C1C_3C6C_CCCC_FE0C_0C0C_0C0C_0000;
            4'd5:    glyph = 128'h0000_7E60_6060_7C06_0606_0606_663C_0000;
            4'd6:    glyph = 128'h0000_3C66_6060_7C66_6666_6666_663C_0000;
            4'd7:    glyph = 128'h0000_7E06_060C_0C18_1818_1818_1818_0000;
            4'd8:    glyph = 128'h0000_3C66_6666_3C66_6666_6666_663C_0000;
            4'd9:    glyph = 128'h0000_3C66_6666_663E_0606_0606_663C_0000;
            default: glyph = '0;
        endcase
    endfunction

    logic [32:0] dx_c, dy_c;
    logic [31:0] didx_c;
    logic        in_c, seen_c;
    logic [3:0]  code_c, dig_c;

    // Bit 32 of dx/dy flags a pixel left of / above the field origin.
    always_comb begin
        dx_c   = {22'd0, px_x} - {1'b0, X0};
        dy_c   = {23'd0, px_y} - {1'b0, Y0};
        in_c   = !dx_c[32] && (dx_c[31:0] < FIELD_W) &&
                 !dy_c[32] && (dy_c[31:0] < FIELD_H);
        didx_c = dx_c[31:0] >> (3 + SCALE_LOG2);
        seen_c = 1'b0;
        code_c = 4'hF;
        dig_c  = '0;
        for (int unsigned p = 0; p < NUM_DIGITS; p++) begin
            dig_c = disp_q[4*(NUM_DIGITS-1-p) +: 4];
            if (dig_c != 4'd0)
                seen_c = 1'b1;
            if (didx_c == p)
                code_c = (LEAD_BLANK && !seen_c && (p != NUM_DIGITS - 1)) ? 4'hF : dig_c;
        end
    end

    logic       in1_q, de1_q, pixel_q, de2_q;
    logic [3:0] code1_q, row1_q;
    logic [2:0] col1_q;
    logic [127:0] glyph_c;

    // Row r occupies bits 127-8r downto 120-8r, column 0 at the MSB.
    assign glyph_c = glyph(code1_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in1_q   <= 1'b0;
            de1_q   <= 1'b0;
            code1_q <= 4'hF;
            row1_q  <= '0;
            col1_q  <= '0;
            pixel_q <= 1'b0;
            de2_q   <= 1'b0;
        end else begin
            in1_q   <= in_c;
            de1_q   <= px_de;
            code1_q <= code_c;
            row1_q  <= 4'(dy_c[31:0] >> SCALE_LOG2);
            col1_q  <= 3'(dx_c[31:0] >> SCALE_LOG2);
            pixel_q <= de1_q & in1_q & glyph_c[~{row1_q, col1_q}];
            de2_q   <= de1_q;
        end
    end

    assign pixel  = pixel_q;
    assign de_out = de2_q;

endmodule

// File: tb/tb_vga_number_render.sv
// Scoreboard bench for vga_number_render: three parameterisations share the
// pixel coordinates; each has its own px_de and expected-pixel queue.
module tb_vga_number_render;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] px_x;
    logic [9:0]  px_y;
    logic        de0, de1, de2;
    logic        busy0, busy1, busy2, ovf0, ovf1, ovf2;
    logic        pix0, pix1, pix2, deo0, deo1, deo2;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;

    typedef struct {
        logic  pix;
        int    cyc;
        string nm;
    } exp_t;
    exp_t q0[$], q1[$], q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vga_number_render_if #(.VAL_W(16)) if0 ();
    vga_number_render_if #(.VAL_W(16)) if1 ();
    vga_number_render_if #(.VAL_W(16)) if2 ();

    vga_number_render #(.VAL_W(16), .NUM_DIGITS(5), .SCALE_LOG2(0), .X0(0), .Y0(0), .LEAD_BLANK(1'b1)) dut0 (
        .clk(clk), .rst(rst), .val(if0), .busy(busy0), .ovf(ovf0),
        .px_x(px_x), .px_y(px_y), .px_de(de0), .pixel(pix0), .de_out(deo0));
    vga_number_render #(.VAL_W(16), .NUM_DIGITS(4), .SCALE_LOG2(0), .X0(0), .Y0(0), .LEAD_BLANK(1'b1)) dut1 (
        .clk(clk), .rst(rst), .val(if1), .busy(busy1), .ovf(ovf1),
        .px_x(px_x), .px_y(px_y), .px_de(de1), .pixel(pix1), .de_out(deo1));
    vga_number_render #(.VAL_W(16), .NUM_DIGITS(5), .SCALE_LOG2(1), .X0(0), .Y0(0), .LEAD_BLANK(1'b0)) dut2 (
        .clk(clk), .rst(rst), .val(if2), .busy(busy2), .ovf(ovf2),
        .px_x(px_x), .px_y(px_y), .px_de(de2), .pixel(pix2), .de_out(deo2));

    task automatic chk(input string nm, input int act, input int req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    function automatic int get_busy(input int sel);
        case (sel)
            0:       return int'(busy0);
            1:       return int'(busy1);
            default: return int'(busy2);
        endcase
    endfunction

    function automatic int get_ready(input int sel);
        case (sel)
            0:       return int'(if0.val_ready);
            1:       return int'(if1.val_ready);
            default: return int'(if2.val_ready);
        endcase
    endfunction

    task automatic set_val(input int sel, input logic v, input logic [15:0] d);
        case (sel)
            0:       begin if0.val_valid = v; if0.val_data = d; end
            1:       begin if1.val_valid = v; if1.val_data = d; end
            default: begin if2.val_valid = v; if2.val_data = d; end
        endcase
    endtask

    // Offer one value, then count busy cycles from the accept edge onwards.
    task automatic send(input int sel, input logic [15:0] d, input string nm);
        int nb = 0;
        int nmis = 0;
        @(negedge clk);
        set_val(sel, 1'b1, d);
        @(posedge clk); #1;
        set_val(sel, 1'b0, d);
        for (int i = 0; i < 40 && get_busy(sel) != 0; i++) begin
            nb++;
            if (get_ready(sel) == get_busy(sel)) nmis++;
            @(posedge clk); #1;
        end
        chk({nm, "_busy_cycles"}, nb, 17);
        chk({nm, "_ready_vs_busy"}, nmis, 0);
    endtask

    task automatic wait_idle(input int sel, input string nm);
        for (int i = 0; i < 40 && get_busy(sel) != 0; i++) begin
            @(posedge clk); #1;
        end
        chk(nm, get_busy(sel), 0);
    endtask

    task automatic pv(input int sel, input int x, input int y, input logic e, input string nm);
        exp_t t;
        @(negedge clk);
        px_x  = 11'(x);
        px_y  = 10'(y);
        de0   = (sel == 0);
        de1   = (sel == 1);
        de2   = (sel == 2);
        t.pix = e;
        t.cyc = cyc;
        t.nm  = nm;
        case (sel)
            0:       q0.push_back(t);
            1:       q1.push_back(t);
            default: q2.push_back(t);
        endcase
    endtask

    task automatic pv_end();
        @(negedge clk);
        de0 = 1'b0;
        de1 = 1'b0;
        de2 = 1'b0;
        for (int i = 0; i < 8 && (q0.size() + q1.size() + q2.size()) > 0; i++)
            @(posedge clk);
        #2;
        chk("sb_drain", q0.size() + q1.size() + q2.size(), 0);
    endtask

    task automatic mon(input int sel, input logic de, input logic pix);
        exp_t e;
        bit   have = 1'b0;
        if (de === 1'b1) begin
            case (sel)
                0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
            endcase
            n_tests++;
            if (!have) begin
                n_fail++;
                $display("FAIL sb%0d_unexpected: de_out=1 pixel=%0b, expected no output", sel, pix);
            end else if (pix !== e.pix || cyc != e.cyc + 2) begin
                n_fail++;
                $display("FAIL %s: pixel=%0b at cycle %0d, expected %0b at cycle %0d",
                         e.nm, pix, cyc, e.pix, e.cyc + 2);
            end
        end else if (pix !== 1'b0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb%0d_pixel_without_de: pixel=%0b, expected 0", sel, pix);
        end
    endtask

    always @(posedge clk) begin
        #1;
        mon(0, deo0, pix0);
        mon(1, deo1, pix1);
        mon(2, deo2, pix2);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        px_x = '0; px_y = '0;
        de0 = 1'b0; de1 = 1'b0; de2 = 1'b0;
        set_val(0, 1'b0, 16'd0);
        set_val(1, 1'b0, 16'd0);
        set_val(2, 1'b0, 16'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_ready", int'(if0.val_ready), 1);
        chk("rst_busy", int'(busy0), 0);
        chk("rst_ovf", int'(ovf0), 0);
        chk("rst_de_out", int'(deo0), 0);

        // Value 0 after reset: only the rightmost digit shows '0'.
        pv(0, 33, 5, 1'b1, "zero_d4_r5c1");
        pv(0, 32, 5, 1'b0, "zero_d4_r5c0");
        pv(0, 35, 5, 1'b0, "zero_d4_r5c3");
        pv(0, 37, 5, 1'b1, "zero_d4_r5c5");
        pv(0, 34, 2, 1'b1, "zero_d4_r2c2");
        pv(0, 33, 2, 1'b0, "zero_d4_r2c1");
        pv(0, 34, 0, 1'b0, "zero_d4_r0");
        pv(0, 1, 5, 1'b0, "zero_blank_d0");
        pv(0, 9, 5, 1'b0, "zero_blank_d1");
        pv(0, 25, 5, 1'b0, "zero_blank_d3");
        pv(0, 40, 5, 1'b0, "zero_outside_x");
        pv(0, 33, 16, 1'b0, "zero_outside_y");
        pv_end();

        // Four-digit field: 9999 fits, 65535 saturates to 9999.
        send(1, 16'd9999, "d1_9999");
        chk("d1_9999_ovf", int'(ovf1), 0);
        pv(1, 2, 7, 1'b1, "d1_9999_d0c2");
        pv_end();
        send(1, 16'd65535, "d1_65535");
        chk("d1_65535_ovf", int'(ovf1), 1);
        pv(1, 2, 7, 1'b1, "sat_d0_r7c2");
        pv(1, 1, 7, 1'b0, "sat_d0_r7c1");
        pv(1, 14, 7, 1'b1, "sat_d1_r7c6");
        pv(1, 23, 7, 1'b0, "sat_d2_r7c7");
        pv(1, 29, 9, 1'b1, "sat_d3_r9c5");
        pv(1, 28, 9, 1'b0, "sat_d3_r9c4");
        pv(1, 32, 7, 1'b0, "sat_outside_x");
        pv_end();

        // x2 scale, no leading blanking, value 1.
        send(2, 16'd1, "d2_one");
        pv(2, 70, 12, 1'b1, "x2_one_y12_x70");
        pv(2, 71, 31, 1'b1, "x2_one_y31_x71");
        pv(2, 73, 20, 1'b1, "x2_one_y20_x73");
        pv(2, 72, 11, 1'b0, "x2_one_y11_dark");
        pv(2, 70, 0, 1'b0, "x2_one_y0_dark");
        pv(2, 69, 20, 1'b0, "x2_one_x69_dark");
        pv(2, 74, 20, 1'b0, "x2_one_x74_dark");
        pv(2, 70, 32, 1'b0, "x2_outside_y");
        pv(2, 2, 10, 1'b1, "x2_leading_zero_shown");
        pv_end();

        send(0, 16'd12345, "d0_12345");
        chk("d0_12345_ovf", int'(ovf0), 0);
        pv(0, 3, 4, 1'b0, "n12345_d0_r4");
        pv(0, 3, 8, 1'b1, "n12345_d0_r8c3");
        pv(0, 2, 8, 1'b0, "n12345_d0_r8c2");
        pv(0, 13, 4, 1'b1, "n12345_d1_r4c5");
        pv(0, 12, 4, 1'b0, "n12345_d1_r4c4");
        pv(0, 9, 13, 1'b1, "n12345_d1_r13c1");
        pv(0, 8, 13, 1'b0, "n12345_d1_r13c0");
        pv(0, 19, 7, 1'b1, "n12345_d2_r7c3");
        pv(0, 18, 7, 1'b0, "n12345_d2_r7c2");
        pv(0, 24, 8, 1'b1, "n12345_d3_r8c0");
        pv(0, 31, 8, 1'b0, "n12345_d3_r8c7");
        pv(0, 33, 3, 1'b1, "n12345_d4_r3c1");
        pv(0, 35, 3, 1'b0, "n12345_d4_r3c3");
        pv(0, 38, 7, 1'b1, "n12345_d4_r7c6");
        pv_end();

        // valid held through CONVERT with a new value: it must not be taken.
        @(negedge clk);
        set_val(0, 1'b1, 16'd42);
        @(posedge clk); #1;
        chk("hold_accept_first", int'(busy0), 1);
        @(negedge clk);
        set_val(0, 1'b1, 16'd7);
        for (int i = 0; i < 40 && if0.val_ready !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        set_val(0, 1'b0, 16'd7);
        chk("hold_ready_back", int'(if0.val_ready), 1);
        pv(0, 24, 8, 1'b1, "hold_first_d3_4");
        pv(0, 33, 13, 1'b1, "hold_first_d4_2");
        pv(0, 32, 13, 1'b0, "hold_first_d4_c0");
        pv(0, 17, 5, 1'b0, "hold_first_d2_blank");
        pv_end();
        @(negedge clk);
        set_val(0, 1'b1, 16'd7);
        @(posedge clk); #1;
        chk("second_accept", int'(busy0), 1);
        set_val(0, 1'b0, 16'd7);
        wait_idle(0, "second_done");
        pv(0, 33, 2, 1'b1, "second_d4_r2c1");
        pv(0, 35, 10, 1'b1, "second_d4_r10c3");
        pv(0, 34, 10, 1'b0, "second_d4_r10c2");
        pv(0, 24, 8, 1'b0, "second_d3_blank");
        pv_end();

        // Reset pulse mid-conversion of 999.
        @(negedge clk);
        set_val(0, 1'b1, 16'd999);
        @(posedge clk); #1;
        chk("r999_accept", int'(busy0), 1);
        set_val(0, 1'b0, 16'd999);
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rstmid_ready", int'(if0.val_ready), 1);
        chk("rstmid_busy", int'(busy0), 0);
        chk("rstmid_ovf1", int'(ovf1), 0);
        chk("rstmid_de_out", int'(deo0), 0);
        chk("rstmid_pixel", int'(pix0), 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        chk("rstmid_no_resume", int'(busy0), 0);
        pv(0, 33, 5, 1'b1, "rstmid_zero_d4");
        pv(0, 25, 5, 1'b0, "rstmid_blank_d3");
        pv_end();

        // First value taken on the first edge after reset release.
        @(negedge clk);
        rst = 1'b1;
        set_val(0, 1'b1, 16'd5);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        chk("first_edge_accept", int'(busy0), 1);
        set_val(0, 1'b0, 16'd5);
        wait_idle(0, "first_edge_done");
        pv(0, 33, 3, 1'b1, "five_d4_r3c1");
        pv(0, 35, 3, 1'b0, "five_d4_r3c3");
        pv_end();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
